eeprom_req_arbiter: RTL and testbench
=====================================

Name: eeprom_req_arbiter

Overview:
Shares the single I2C EEPROM controller between two independent requesters, e.g. a config loader and a host register port. It arbitrates round-robin, drives the controller's RD/WR strobes, address and write data, and detects transaction completion from RD_END/WR_END edges. It returns read data and a one-cycle done pulse to the granted requester. It sits directly above the EEPROM controller; the top level resolves the controller's tri-state DATA bus from EE_WDATA/EE_DATA_OE/EE_RDATA.

Parameters:
ISSUE_CYCLES, 4, cycles RD/WR strobe is held high (≥2 so the controller sees it in its SCL-high phase)
TIMEOUT_CYCLES, 65535, WAIT_END cycle limit (used only with EEPROM_ARB_TIMEOUT_EN)
TO_W, 16, width of the timeout counter

Ports:
CLK  in  1  system clock, same as controller
RESET  in  1  synchronous active-high reset
REQ0/REQ1  in  1  request; level, held until the matching DONE
WE0/WE1  in  1  1=write, 0=read; stable while REQ high
ADDR0/ADDR1  in  11  EEPROM byte address; stable while REQ high
WDATA0/WDATA1  in  8  write byte; stable while REQ high
DONE0/DONE1  out  1  one-cycle completion pulse
RDATA  out  8  read byte, valid with DONEx and held until the next completion
ERR  out  1  one-cycle pulse coincident with DONEx on timeout
BUSY  out  1  high in any state other than IDLE
EE_RD  out  1  controller read strobe
EE_WR  out  1  controller write strobe
EE_ADDR  out  11  controller address
EE_WDATA  out  8  byte to drive onto the controller DATA bus
EE_DATA_OE  out  1  top level drives DATA=EE_WDATA when high
EE_RDATA  in  8  controller DATA bus value
EE_RD_END  in  1  controller read-complete level
EE_WR_END  in  1  controller write-complete level

Behaviour:
- Clocking and reset: one clock CLK; reset RESET is synchronous, active-high.
- Reset values: state=IDLE, priority pointer=0, all strobes, DONEx, ERR, BUSY and EE_DATA_OE at 0; RDATA, EE_ADDR and EE_WDATA at 0.
- A reset mid-transaction abandons it with no DONE. The system asserts the controller reset together with this block's reset.
- States:
  - IDLE → ISSUE when any REQ is high.
  - ISSUE → WAIT_END after ISSUE_CYCLES cycles.
  - WAIT_END → DONE on completion (or on timeout).
  - DONE → IDLE after 1 cycle.
- Arbitration, in IDLE:
  - If only one REQ is high, grant it.
  - If both are high, grant the requester selected by the pointer.
  - The pointer flips to the non-granted index on every grant.
- On grant, the cycle IDLE→ISSUE:
  - Latch gnt, WE, ADDR and WDATA internally.
  - EE_ADDR and EE_WDATA come from the latches and stay stable until leaving DONE.
  - EE_DATA_OE = latched WE from ISSUE through DONE.
- ISSUE: EE_RD = ~WE or EE_WR = WE, held high for exactly ISSUE_CYCLES cycles, then low. A down-counter holds the count.
- End-flag edge detection: EE_RD_END and EE_WR_END are registered every cycle (prev). The controller leaves END flags high until its next start.
- Completion in WAIT_END is the rising edge of the flag for the latched direction: END & ~prev. The other flag is ignored.
- Read completion: RDATA <= EE_RDATA in the same cycle the rising edge is seen.
- DONE state: DONE[gnt]=1 for that single cycle.
- A requester may reassert REQ the cycle after its DONE. It is re-arbitrated normally and may win again if the other is idle.
- REQ deasserted mid-transaction: ignored; the transaction completes and DONE is still pulsed.
- Simultaneous end edge and timeout in the same cycle: completion wins and ERR=0.

Optional Feature:
EEPROM_ARB_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on entering WAIT_END and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES, go to DONE with ERR=1, RDATA unchanged, strobes low.
- Undefined:
  - No counter is built; ERR is tied 0.
  - WAIT_END waits indefinitely for the end edge.

Decomposition:
- Package eeprom_arb_pkg holds:
  - the state encoding (IDLE, ISSUE, WAIT_END, DONE, one-hot, 4 bits);
  - EEPROM address width 11 and data width 8.
- One natural sub-module, eeprom_rr_pick: 2-way round-robin picker (REQ[1:0], pointer → grant index, valid).

Test Plan:
- REQ0 read at ADDR0=0x155: EE_RD high for 4 cycles; controller model raises EE_RD_END with EE_RDATA=0xA5 → RDATA=0xA5, DONE0 one cycle, DONE1 never.
- REQ1 write ADDR1=0x7FF, WDATA1=0x3C: EE_WR high for 4 cycles; EE_ADDR=0x7FF and EE_WDATA=0x3C with EE_DATA_OE=1 until DONE1; completes on EE_WR_END rising.
- REQ0 and REQ1 high together, three times each → grant order 0,1,0,1,0,1; no overlap of EE_RD/EE_WR windows.
- EE_RD_END already high from the prior read when a new read is issued → no DONE until the flag falls and rises again.
- RESET asserted in WAIT_END → next cycle state IDLE, all outputs 0, pointer 0, no DONE pulse.
- With EEPROM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20, no end edge → DONE0 and ERR on WAIT_END cycle 20, RDATA unchanged; without the macro the block stays BUSY.

Source files
------------

// File: rtl/eeprom_arb_pkg.sv
// eeprom_arb_pkg: one-hot state encoding and bus widths shared by the EEPROM request arbiter
package eeprom_arb_pkg;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam logic [3:0] S_IDLE     = 4'b0001;
  localparam logic [3:0] S_ISSUE    = 4'b0010;
  localparam logic [3:0] S_WAIT_END = 4'b0100;
  localparam logic [3:0] S_DONE     = 4'b1000;
endpackage

// File: rtl/eeprom_req_arbiter_if.sv
// eeprom_req_arbiter_if: two requester ports plus the EEPROM controller strobe/data/end-flag bus
// slave modport is the arbiter; master modport is the surrounding system (requesters + controller)
interface eeprom_req_arbiter_if;
  import eeprom_arb_pkg::*;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          done0, done1, err, busy;
  logic [DW-1:0] rdata;
  logic          ee_rd, ee_wr, ee_data_oe;
  logic [AW-1:0] ee_addr;
  logic [DW-1:0] ee_wdata, ee_rdata;
  logic          ee_rd_end, ee_wr_end;
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ee_rdata, ee_rd_end, ee_wr_end,
    output done0, done1, rdata, err, busy, ee_rd, ee_wr, ee_addr, ee_wdata, ee_data_oe
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ee_rdata, ee_rd_end, ee_wr_end,
    input  done0, done1, rdata, err, busy, ee_rd, ee_wr, ee_addr, ee_wdata, ee_data_oe
  );
endinterface

// File: rtl/eeprom_rr_pick.sv
// eeprom_rr_pick: 2-way round-robin picker; req[1:0] + pointer -> granted index idx, vld when any request
module eeprom_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       idx,
  output logic       vld
);
  always_comb begin
    vld = |req;
    idx = &req ? ptr : req[1];
  end
endmodule

// File: rtl/eeprom_req_arbiter.sv
// eeprom_req_arbiter: round-robin share of one I2C EEPROM controller between two requesters
// Ports: CLK, RESET (sync, active-high); bus (slave modport) carries REQx/WEx/ADDRx/WDATAx in,
// DONEx/RDATA/ERR/BUSY out, and the controller side EE_RD/EE_WR/EE_ADDR/EE_WDATA/EE_DATA_OE out,
// EE_RDATA/EE_RD_END/EE_WR_END in.
// Optional macro EEPROM_ARB_TIMEOUT_EN: WAIT_END gives up after TIMEOUT_CYCLES cycles with ERR.
module eeprom_req_arbiter
  import eeprom_arb_pkg::*;
#(
  parameter int ISSUE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TO_W           = 16
) (
  input logic CLK,
  input logic RESET,
  eeprom_req_arbiter_if.slave bus
);
  localparam int IW = $clog2(ISSUE_CYCLES);
  logic [3:0]    state_q, state_d;
  logic          ptr_q, ptr_d, gnt_q, gnt_d, we_q, we_d, err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          rd_prev_q, wr_prev_q;
  logic          idx, vld, edge_hit, to_hit;

  eeprom_rr_pick u_pick (.req({bus.req1, bus.req0}), .ptr(ptr_q), .idx(idx), .vld(vld));

`ifdef EEPROM_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
  always_comb begin
    to_d   = state_q == S_WAIT_END ? to_q + TO_W'(1) : '0;
    to_hit = state_q == S_WAIT_END && to_q == TO_W'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge CLK) to_q <= RESET ? '0 : to_d;
`else
  always_comb to_hit = TO_W == 0 && TIMEOUT_CYCLES == 0;
`endif

  always_comb begin
    // the controller leaves END high until its next start, so only a fresh rise means completion
    edge_hit = we_q ? bus.ee_wr_end & ~wr_prev_q : bus.ee_rd_end & ~rd_prev_q;
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = state_q == S_ISSUE ? cnt_q - IW'(1) : cnt_q;
    if (state_q == S_IDLE && vld) begin
      state_d = S_ISSUE;
      ptr_d   = ~idx;
      gnt_d   = idx;
      we_d    = idx ? bus.we1 : bus.we0;
      addr_d  = idx ? bus.addr1 : bus.addr0;
      wdata_d = idx ? bus.wdata1 : bus.wdata0;
      cnt_d   = IW'(ISSUE_CYCLES - 1);
    end
    if (state_q == S_ISSUE && cnt_q == '0) state_d = S_WAIT_END;
    if (state_q == S_WAIT_END && (edge_hit || to_hit)) begin
      state_d = S_DONE;
      err_d   = ~edge_hit;
      rdata_d = edge_hit && !we_q ? bus.ee_rdata : rdata_q;
    end
    if (state_q == S_DONE) state_d = S_IDLE;
  end

  always_comb begin
    bus.ee_rd      = state_q == S_ISSUE && !we_q;
    bus.ee_wr      = state_q == S_ISSUE && we_q;
    bus.ee_addr    = addr_q;
    bus.ee_wdata   = wdata_q;
    bus.ee_data_oe = we_q && state_q != S_IDLE;
    bus.done0      = state_q == S_DONE && !gnt_q;
    bus.done1      = state_q == S_DONE && gnt_q;
    bus.err        = state_q == S_DONE && err_q;
    bus.busy       = state_q != S_IDLE;
    bus.rdata      = rdata_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      rd_prev_q <= bus.ee_rd_end;
      wr_prev_q <= bus.ee_wr_end;
    end
  end
endmodule

// File: tb/tb_eeprom_req_arbiter.sv
// tb_eeprom_req_arbiter: directed scoreboard bench with a behavioural EEPROM controller model
module tb_eeprom_req_arbiter;
  import eeprom_arb_pkg::*;
  typedef struct {
    logic          idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  eeprom_req_arbiter_if bus();
  eeprom_req_arbiter #(.ISSUE_CYCLES(4), .TIMEOUT_CYCLES(20), .TO_W(16)) dut (
    .CLK(clk), .RESET(rst), .bus(bus)
  );
  always #5 clk = ~clk;

  exp_t          sb[$];
  int            checks = 0, failures = 0;
  int            swidth = 0, wcnt = 0, last_wait = 0, ndone = 0;
  logic [DW-1:0] exp_rdata = '0;
  logic          mptr = 1'b0, exp_err = 1'b0, mdl_en = 1'b1;
  int            clr_at = 1, set_at = 8;
  logic [DW-1:0] mdl_rdata = '0;
  logic          strb_prev = 1'b0, act = 1'b0, pdir_wr = 1'b0;
  int            t = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // controller model: clears the END flag clr_at cycles after a start, raises it at set_at
  always @(posedge clk) begin
    if (rst) begin
      bus.ee_rd_end <= 1'b0;
      bus.ee_wr_end <= 1'b0;
      bus.ee_rdata  <= '0;
      act <= 1'b0;
      strb_prev <= 1'b0;
      t <= 0;
    end else begin
      strb_prev <= bus.ee_rd | bus.ee_wr;
      if ((bus.ee_rd | bus.ee_wr) && !strb_prev) begin
        act <= 1'b1;
        t <= 1;
        pdir_wr <= bus.ee_wr;
      end else if (act) begin
        t <= t + 1;
        if (t == clr_at) begin
          if (pdir_wr) bus.ee_wr_end <= 1'b0;
          else bus.ee_rd_end <= 1'b0;
        end
        if (t == set_at && mdl_en) begin
          if (pdir_wr) bus.ee_wr_end <= 1'b1;
          else begin
            bus.ee_rd_end <= 1'b1;
            bus.ee_rdata <= mdl_rdata;
          end
          act <= 1'b0;
        end
      end
    end
  end

  // monitor: strobe shape/direction at strobe start, completion popped from the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      swidth = 0;
      wcnt = 0;
    end else begin
      if (bus.ee_rd | bus.ee_wr) begin
        if (swidth == 0) begin
          if (sb.size() == 0) chk("strobe_without_request", 32'(1), 32'(0));
          else begin
            chk("strobe_dir_wr", 32'(bus.ee_wr), 32'(sb[0].we));
            chk("strobe_dir_rd", 32'(bus.ee_rd), 32'(!sb[0].we));
            chk("issue_addr", 32'(bus.ee_addr), 32'(sb[0].addr));
            chk("issue_oe", 32'(bus.ee_data_oe), 32'(sb[0].we));
          end
        end
        swidth++;
        wcnt = 0;
      end else begin
        if (swidth != 0) chk("strobe_width", swidth, 4);
        swidth = 0;
        if (bus.busy && !bus.done0 && !bus.done1) wcnt++;
      end
      if (bus.done0 || bus.done1) begin
        chk("done_exclusive", 32'(bus.done0 & bus.done1), 32'(0));
        if (sb.size() == 0) chk("unexpected_done", 32'(1), 32'(0));
        else begin
          exp_t e;
          e = sb.pop_front();
          if (!e.we && !e.err) exp_rdata = e.rdata;
          chk("done_idx", 32'(bus.done1), 32'(e.idx));
          chk("done_err", 32'(bus.err), 32'(e.err));
          chk("done_rdata", 32'(bus.rdata), 32'(exp_rdata));
          chk("done_addr", 32'(bus.ee_addr), 32'(e.addr));
          chk("done_oe", 32'(bus.ee_data_oe), 32'(e.we));
          if (e.we) chk("done_wdata", 32'(bus.ee_wdata), 32'(e.wdata));
        end
        last_wait = wcnt;
        wcnt = 0;
        ndone++;
      end
    end
  end

  function automatic exp_t mk(input logic g);
    exp_t e;
    e.idx   = g;
    e.we    = g ? bus.we1 : bus.we0;
    e.addr  = g ? bus.addr1 : bus.addr0;
    e.wdata = g ? bus.wdata1 : bus.wdata0;
    e.rdata = mdl_rdata;
    e.err   = exp_err;
    return e;
  endfunction

  task automatic run_jobs(input int a, input int b);
    int n0, n1, m0, m1, budget;
    logic g;
    n0 = a; n1 = b; m0 = a; m1 = b;
    while (m0 > 0 || m1 > 0) begin
      g = (m0 > 0 && m1 > 0) ? mptr : (m1 > 0);
      sb.push_back(mk(g));
      mptr = ~g;
      if (g) m1--;
      else m0--;
    end
    bus.req0 = n0 > 0;
    bus.req1 = n1 > 0;
    budget = 0;
    while ((n0 > 0 || n1 > 0) && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (bus.done0) begin n0--; if (n0 == 0) bus.req0 = 1'b0; end
      if (bus.done1) begin n1--; if (n1 == 0) bus.req1 = 1'b0; end
    end
    chk("jobs_finished_in_budget", 32'(budget < 2000), 32'(1));
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "_ee_rd"}, 32'(bus.ee_rd), 32'(0));
    chk({tag, "_ee_wr"}, 32'(bus.ee_wr), 32'(0));
    chk({tag, "_oe"}, 32'(bus.ee_data_oe), 32'(0));
    chk({tag, "_done"}, 32'({bus.done1, bus.done0}), 32'(0));
    chk({tag, "_err"}, 32'(bus.err), 32'(0));
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'(0));
    chk({tag, "_ee_addr"}, 32'(bus.ee_addr), 32'(0));
    chk({tag, "_ee_wdata"}, 32'(bus.ee_wdata), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d0;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    // single read by requester 0
    bus.addr0 = 11'h155; mdl_rdata = 8'hA5;
    run_jobs(1, 0);
    chk("read_wait_cycles", last_wait, 6);
    // END flag still high from the prior read must not count as completion
    clr_at = 10; set_at = 14; mdl_rdata = 8'h11;
    run_jobs(1, 0);
    chk("stale_end_wait_cycles", last_wait, 12);
    clr_at = 1; set_at = 8;
    // single write by requester 1
    bus.we1 = 1'b1; bus.addr1 = 11'h7FF; bus.wdata1 = 8'h3C;
    run_jobs(0, 1);
    // contention: alternating grants
    bus.addr0 = 11'h001; bus.addr1 = 11'h400; bus.wdata1 = 8'hC3; mdl_rdata = 8'h5A;
    run_jobs(3, 3);
    // back-to-back reassertion by one requester
    mdl_rdata = 8'h77;
    run_jobs(2, 0);
    // reset while waiting for the end flag
    mdl_en = 1'b0;
    bus.addr0 = 11'h2AA;
    sb.push_back(mk(1'b0));
    bus.req0 = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.busy && !bus.ee_rd && !bus.ee_wr) && k < 50);
    chk("reached_wait_end", 32'(k < 50), 32'(1));
    repeat (3) @(negedge clk);
    sb.delete();
    bus.req0 = 1'b0;
    rst = 1'b1;
    d0 = ndone;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("midreset");
    exp_rdata = '0;
    mptr = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_done_after_reset", ndone, d0);
    mdl_en = 1'b1; mdl_rdata = 8'h99;
    run_jobs(1, 1);
    // no end edge at all
    mdl_en = 1'b0;
    bus.addr0 = 11'h0F0;
`ifdef EEPROM_ARB_TIMEOUT_EN
    exp_err = 1'b1;
    run_jobs(1, 0);
    chk("timeout_wait_cycles", last_wait, 20);
    exp_err = 1'b0;
`else
    sb.push_back(mk(1'b0));
    bus.req0 = 1'b1;
    d0 = ndone;
    repeat (80) @(negedge clk);
    chk("no_timeout_busy", 32'(bus.busy), 32'(1));
    chk("no_timeout_done", ndone, d0);
    bus.req0 = 1'b0;
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
